// File: rtl/vec_assembler.sv
// Rebuilds a WIDTH-bit mask from a stream of (cnt, empty) bit indices and emits it on the last beat.
// Optional duplicate-index detection is enabled with `define VEC_ASSEMBLER_DUP_CHECK_EN.
module vec_assembler #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic [CNT_WIDTH-1:0] in_idx_i,
    input  logic                 in_empty_i,
    input  logic                 in_last_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [WIDTH-1:0]     out_vec_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
`ifdef VEC_ASSEMBLER_DUP_CHECK_EN
    output logic                 dup_o,
`endif
    output logic                 err_o
);

    localparam int unsigned CW1 = CNT_WIDTH + 1;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [WIDTH-1:0] dec;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             in_fire, out_fire, in_range;
    logic [CW1-1:0]   idx_ext;

    // Index is widened by one bit so WIDTH itself is representable in the range test.
    assign idx_ext  = {1'b0, in_idx_i};
    assign in_range = (idx_ext < CW1'(WIDTH));

    assign in_ready_o = !clr_i && (!valid_q || out_ready_i);
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = valid_q && out_ready_i;

    // One-hot decode; MODE selects whether index 0 maps to the LSB or the MSB.
    for (genvar g = 0; g < WIDTH; g++) begin : g_dec
        assign dec[g] = !in_empty_i && in_range &&
                        (idx_ext == (MODE ? CW1'(WIDTH - 1 - g) : CW1'(g)));
    end

    always_comb begin
        acc_d   = acc_q;
        vec_d   = vec_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (clr_i) begin
            acc_d   = '0;
            vec_d   = '0;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else begin
            if (out_fire) begin
                valid_d = 1'b0;
            end
            if (in_fire) begin
                if (!in_empty_i && !in_range) begin
                    err_d = 1'b1;
                end
                if (in_last_i) begin
                    vec_d   = acc_q | dec;
                    valid_d = 1'b1;
                    acc_d   = '0;
                end else begin
                    acc_d = acc_q | dec;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q   <= '0;
            vec_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_vec_o   = vec_q;
    assign out_valid_o = valid_q;
    assign err_o       = err_q;

`ifdef VEC_ASSEMBLER_DUP_CHECK_EN
    logic dup_q, dup_d;

    // Only bits gathered earlier in the current frame count as duplicates.
    always_comb begin
        dup_d = dup_q;
        if (clr_i) begin
            dup_d = 1'b0;
        end else if (in_fire && |(acc_q & dec)) begin
            dup_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dup_q <= 1'b0;
        end else begin
            dup_q <= dup_d;
        end
    end

    assign dup_o = dup_q;
`endif

endmodule

// File: tb/tb_vec_assembler.sv
// Scoreboard bench for vec_assembler: three instances (8/LSB, 8/MSB, 6/LSB) share clock and reset.
module tb_vec_assembler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] idx  [3];
    logic       emp  [3];
    logic       lst  [3];
    logic       vld  [3];
    logic       ordy [3];
    logic       clr  [3];
    logic       irdy [3];
    logic       ovld [3];
    logic       err  [3];
    logic [7:0] vec0, vec1;
    logic [5:0] vec2;
`ifdef VEC_ASSEMBLER_DUP_CHECK_EN
    logic       dup  [3];
`endif

    int checks   = 0;
    int failures = 0;

    int         widths [3] = '{8, 8, 6};
    bit         modes  [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] exp_acc [3];
    bit         exp_err [3];
    bit         exp_dup [3];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    always #5 clk = ~clk;

    vec_assembler #(.WIDTH(8), .MODE(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[0]), .in_idx_i(idx[0]),
        .in_empty_i(emp[0]), .in_last_i(lst[0]), .in_valid_i(vld[0]), .in_ready_o(irdy[0]),
        .out_vec_o(vec0), .out_valid_o(ovld[0]), .out_ready_i(ordy[0]),
`ifdef VEC_ASSEMBLER_DUP_CHECK_EN
        .dup_o(dup[0]),
`endif
        .err_o(err[0]));

    vec_assembler #(.WIDTH(8), .MODE(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[1]), .in_idx_i(idx[1]),
        .in_empty_i(emp[1]), .in_last_i(lst[1]), .in_valid_i(vld[1]), .in_ready_o(irdy[1]),
        .out_vec_o(vec1), .out_valid_o(ovld[1]), .out_ready_i(ordy[1]),
`ifdef VEC_ASSEMBLER_DUP_CHECK_EN
        .dup_o(dup[1]),
`endif
        .err_o(err[1]));

    vec_assembler #(.WIDTH(6), .MODE(1'b0)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[2]), .in_idx_i(idx[2]),
        .in_empty_i(emp[2]), .in_last_i(lst[2]), .in_valid_i(vld[2]), .in_ready_o(irdy[2]),
        .out_vec_o(vec2), .out_valid_o(ovld[2]), .out_ready_i(ordy[2]),
`ifdef VEC_ASSEMBLER_DUP_CHECK_EN
        .dup_o(dup[2]),
`endif
        .err_o(err[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] vec_of(input int d);
        case (d)
            0:       return vec0;
            1:       return vec1;
            default: return {2'b00, vec2};
        endcase
    endfunction

    task automatic sb_push(input int d, input logic [7:0] v);
        case (d)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic sb_pop(input int d, output bit ok, output logic [7:0] v);
        ok = 1'b0;
        v  = '0;
        case (d)
            0:       if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Output monitor: every output handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (ovld[d] && ordy[d]) begin
                    bit         ok;
                    logic [7:0] v;
                    sb_pop(d, ok, v);
                    check($sformatf("sb_present%0d", d), 32'(ok), 32'd1);
                    if (ok) check($sformatf("sb_vec%0d", d), 32'(vec_of(d)), 32'(v));
                end
            end
        end
    end

    // Drives one beat, waits for acceptance, and updates the reference model.
    task automatic beat(input int d, input int ix, input bit e, input bit l);
        int         n = 0;
        bit         ok = 1'b1;
        logic [7:0] b = '0;
        int         w = widths[d];
        idx[d] = 3'(ix);
        emp[d] = e;
        lst[d] = l;
        vld[d] = 1'b1;
        while (1) begin
            @(negedge clk);
            if (irdy[d]) break;
            n++;
            if (n > 100) begin
                check($sformatf("beat_timeout%0d", d), 32'd0, 32'd1);
                ok = 1'b0;
                break;
            end
        end
        if (ok) begin
            if (!e) begin
                if (ix < w) b = 8'(1) << (modes[d] ? (w - 1 - ix) : ix);
                else        exp_err[d] = 1'b1;
            end
            if ((b & exp_acc[d]) != 0) exp_dup[d] = 1'b1;
            if (l) begin
                sb_push(d, exp_acc[d] | b);
                exp_acc[d] = '0;
            end else begin
                exp_acc[d] = exp_acc[d] | b;
            end
        end
        @(posedge clk);
        #1;
        vld[d] = 1'b0;
        lst[d] = 1'b0;
        emp[d] = 1'b0;
    endtask

    task automatic pulse_clr(input int d);
        clr[d] = 1'b1;
        @(posedge clk);
        #1;
        clr[d] = 1'b0;
        exp_acc[d] = '0;
        exp_err[d] = 1'b0;
        exp_dup[d] = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            idx[d] = '0; emp[d] = 1'b0; lst[d] = 1'b0; vld[d] = 1'b0;
            ordy[d] = 1'b1; clr[d] = 1'b0;
            exp_acc[d] = '0; exp_err[d] = 1'b0; exp_dup[d] = 1'b0;
        end
        cycles(3);
        rst_n = 1'b1;
        cycles(1);

        check("rst_valid", 32'(ovld[0]), 32'd0);
        check("rst_vec",   32'(vec0),    32'd0);
        check("rst_err",   32'(err[0]),  32'd0);
        check("rst_ready", 32'(irdy[0]), 32'd1);

        // LSB-indexed frame 3, 0, 7
        beat(0, 3, 1'b0, 1'b0);
        beat(0, 0, 1'b0, 1'b0);
        beat(0, 7, 1'b0, 1'b1);
        check("t1_valid", 32'(ovld[0]), 32'd1);
        check("t1_vec",   32'(vec0),    32'h89);
        check("t1_err",   32'(err[0]),  32'd0);

        // MSB-indexed single beat, then an empty frame
        beat(1, 0, 1'b0, 1'b1);
        check("t2_vec", 32'(vec1), 32'h80);
        beat(1, 0, 1'b1, 1'b1);
        check("t2_empty_valid", 32'(ovld[1]), 32'd1);
        check("t2_empty_vec",   32'(vec1),    32'h00);

        // Backpressure then back-to-back replacement
        ordy[0] = 1'b0;
        beat(0, 3, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            check("bp_ready", 32'(irdy[0]), 32'd0);
            check("bp_valid", 32'(ovld[0]), 32'd1);
            check("bp_vec",   32'(vec0),    32'h08);
        end
        ordy[0] = 1'b1;
        beat(0, 1, 1'b0, 1'b1);
        check("b2b_valid", 32'(ovld[0]), 32'd1);
        check("b2b_vec",   32'(vec0),    32'h02);

        // Out-of-range index on the 6-bit instance
        beat(2, 6, 1'b0, 1'b0);
        beat(2, 2, 1'b0, 1'b1);
        check("oor_vec", 32'(vec2),   32'h04);
        check("oor_err", 32'(err[2]), 32'(exp_err[2]));
        cycles(3);
        check("oor_err_sticky", 32'(err[2]), 32'd1);
        pulse_clr(2);
        check("oor_err_clr", 32'(err[2]), 32'd0);

        // Clear collides with a last-beat handshake
        cycles(2);
        clr[0] = 1'b1; vld[0] = 1'b1; idx[0] = 3'd5; lst[0] = 1'b1;
        @(negedge clk);
        check("clr_ready", 32'(irdy[0]), 32'd0);
        @(posedge clk);
        #1;
        clr[0] = 1'b0; vld[0] = 1'b0; lst[0] = 1'b0;
        exp_acc[0] = '0; exp_err[0] = 1'b0; exp_dup[0] = 1'b0;
        check("clr_valid", 32'(ovld[0]), 32'd0);
        beat(0, 1, 1'b0, 1'b1);
        check("clr_next_vec", 32'(vec0), 32'h02);

        // Duplicate index within one frame
        beat(0, 4, 1'b0, 1'b0);
        beat(0, 4, 1'b0, 1'b1);
        check("dup_vec", 32'(vec0), 32'h10);
`ifdef VEC_ASSEMBLER_DUP_CHECK_EN
        check("dup_flag", 32'(dup[0]), 32'(exp_dup[0]));
        pulse_clr(0);
        check("dup_clr", 32'(dup[0]), 32'd0);
`endif

        cycles(4);
        check("sb_drain0", 32'(q0.size()), 32'd0);
        check("sb_drain1", 32'(q1.size()), 32'd0);
        check("sb_drain2", 32'(q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vec_assembler.md
Name: vec_assembler

Overview:
- Streaming inverse of the zero-counter encoder: accepts a stream of bit indices in the counter's (cnt, empty) format, decodes each to a one-hot position and ORs it into an accumulator.
- On a beat flagged last, emits the assembled WIDTH-bit vector on a registered valid/ready output.
- Sits downstream of index producers, e.g. arbiter or scheduler drain loops, to rebuild request/grant masks from serialised indices.

Parameters:
- WIDTH, 8, width of the assembled vector; must be >= 1.
- MODE, 1'b0, index interpretation: 0 -> index counts from LSB (bit idx); 1 -> index counts from MSB (bit WIDTH-1-idx).
- CNT_WIDTH, cf_math_pkg::idx_width(WIDTH), dependent parameter (do not override); width of the index input.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- clr_i  in  1  synchronous flush: clears accumulator, output register and err_o
- in_idx_i  in  CNT_WIDTH  bit index, MODE-interpreted
- in_empty_i  in  1  beat carries no bit; in_idx_i ignored
- in_last_i  in  1  final beat of the current vector
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when valid&ready
- out_vec_o  out  WIDTH  assembled vector
- out_valid_o  out  1  out_vec_o valid
- out_ready_i  in  1  downstream accepts
- err_o  out  1  sticky: an out-of-range index (in_idx_i >= WIDTH, not empty) was accepted

Behaviour:
- Reset (async assert, sync release): acc = 0, out_vec_o = 0, out_valid_o = 0, err_o = 0.
- States are implicit in out_valid_o:
  - ACCUM (out_valid_o = 0).
  - HOLD (out_valid_o = 1).
- in_ready_o = !out_valid_o | out_ready_i. In HOLD, a new beat is accepted only in a cycle where the held vector is taken. There is no combinational path from in_valid_i to out_valid_o.
- Decode of an accepted beat:
  - pos = MODE ? WIDTH-1-in_idx_i : in_idx_i.
  - bit = (!in_empty_i && in_idx_i < WIDTH) ? 1 << pos : 0.
  - Comparison uses CNT_WIDTH+1-bit unsigned arithmetic.
- Accepted beat, in_last_i = 0: acc <= acc | bit. Output is unchanged.
- Accepted beat, in_last_i = 1:
  - out_vec_o <= acc | bit, out_valid_o <= 1, acc <= 0.
  - Latency is 1 cycle from the last-beat handshake to out_valid_o.
- Output handshake without a new last beat: out_valid_o & out_ready_i -> out_valid_o <= 0. out_vec_o holds its value, don't-care to consumers.
- Simultaneous output handshake and accepted last beat: the new vector is loaded and out_valid_o stays 1, giving back-to-back throughput of 1 vector/cycle.
- Single-beat vector (last on the first beat) is legal. An empty+last beat emits acc unchanged, which may be all-zero.
- Duplicate indices within a vector are idempotent (OR).
- Out-of-range index (only reachable when WIDTH is not a power of two, or WIDTH == 1 with idx 1):
  - contributes no bit;
  - err_o <= 1 and stays set until clr_i or reset;
  - the frame otherwise proceeds normally.
- clr_i has priority over every other update in its cycle:
  - acc, out_valid_o and err_o are cleared;
  - any beat handshaking that cycle is discarded;
  - in_ready_o is forced 0 while clr_i = 1.
- Reset mid-frame drops the partial accumulator and the held output with no flush beat.
- WIDTH == 1: CNT_WIDTH = 1. Idx 0 sets bit 0; idx 1 is out-of-range. This mirrors the encoder's count of 1 for an all-zero input.
- out_valid_o is stable until handshake; out_vec_o is stable while out_valid_o & !out_ready_i.

Optional Feature:
- Macro VEC_ASSEMBLER_DUP_CHECK_EN.
- Defined:
  - adds output dup_o (1 bit, reset 0);
  - set sticky when an accepted non-empty, in-range beat targets a bit already set in acc for the current frame (acc | bit of earlier beats, not previous frames);
  - cleared by clr_i or reset.
- Undefined: port absent, no extra logic, behaviour otherwise identical.

Test Plan:
- WIDTH=8, MODE=0: beats idx 3, 0, then 7+last -> one cycle later out_valid_o=1, out_vec_o=8'h89, err_o=0.
- WIDTH=8, MODE=1: single beat idx 0+last -> out_vec_o=8'h80; then empty+last -> out_vec_o=8'h00, out_valid_o=1.
- Backpressure: out_ready_i=0 while a vector is held -> in_ready_o=0, out_vec_o stable for 5 cycles. Raise out_ready_i together with a new idx 1+last -> out_vec_o=8'h02 next cycle, out_valid_o stays 1, no cycle lost.
- WIDTH=6, MODE=0: idx 6, then idx 2+last -> out_vec_o=6'h04, err_o=1 and stays 1 until clr_i pulse.
- clr_i asserted in the same cycle as an idx 5+last handshake -> no output, in_ready_o=0 that cycle. Next frame idx 1+last -> 8'h02 only.
- With VEC_ASSEMBLER_DUP_CHECK_EN: beats idx 4, 4+last -> out_vec_o=8'h10, dup_o=1. Without the macro the same stimulus gives 8'h10 and no dup_o port.
